// File: rtl/nanorv32_ahb_arb2_pkg.sv
// Shared AHB constants and encodings for the two-master nanorv32 AHB arbiter.
package nanorv32_ahb_arb2_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DATA = 2'd2
    } stage_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_D    = 2'd1,
        OWN_I    = 2'd2
    } owner_e;

endpackage

// File: rtl/nanorv32_ahb_arb_in_stage.sv
// Per-master input stage: accepts an address phase at once and holds it while the slave is taken.
module nanorv32_ahb_arb_in_stage
    import nanorv32_ahb_arb2_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        htrans,
    input  logic [ADDR_W-1:0] haddr,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic              grant,
    input  logic              s_hready,
    output logic              hready,
    output logic              cand,
    output logic [ADDR_W-1:0] a_haddr,
    output logic              a_hwrite,
    output logic [2:0]        a_hsize
);

    stage_state_e      state_q, state_d;
    logic [ADDR_W-1:0] hold_addr;
    logic              hold_write;
    logic [2:0]        hold_size;
    logic              req;
    logic              take;
    logic              hold_en;
    logic              unused_htrans0;

    // Only htrans[1] distinguishes an active transfer; SEQ and NONSEQ are treated alike.
    assign unused_htrans0 = htrans[0];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, master handshake and address-phase source selection.
    always_comb begin
        hready   = 1'b1;
        state_d  = state_q;
        case (state_q)
            ST_WAIT: hready = 1'b0;
            ST_DATA: hready = s_hready;
            default: hready = 1'b1;
        endcase

        req     = htrans[1] & hready;
        take    = grant & s_hready;
        cand    = (state_q == ST_WAIT) | req;
        hold_en = req & ~take;

        if (state_q == ST_WAIT) begin
            if (take) begin
                state_d = ST_DATA;
            end
        end else if ((state_q == ST_IDLE) || s_hready) begin
            if (req) begin
                state_d = take ? ST_DATA : ST_WAIT;
            end else begin
                state_d = ST_IDLE;
            end
        end

        if (state_q == ST_WAIT) begin
            a_haddr  = hold_addr;
            a_hwrite = hold_write;
            a_hsize  = hold_size;
        end else begin
            a_haddr  = haddr;
            a_hwrite = hwrite;
            a_hsize  = hsize;
        end
    end

    // Hold register captures an accepted address phase that could not be forwarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_addr  <= '0;
            hold_write <= 1'b0;
            hold_size  <= 3'd0;
        end else if (hold_en) begin
            hold_addr  <= haddr;
            hold_write <= hwrite;
            hold_size  <= hsize;
        end
    end

endmodule

// File: rtl/nanorv32_ahb_arb2.sv
// Two-master (D, I) to one-slave AHB-lite arbiter with D priority and an I anti-starvation count.
module nanorv32_ahb_arb2
    import nanorv32_ahb_arb2_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MAX_D_GRANTS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        d_htrans,
    input  logic [ADDR_W-1:0] d_haddr,
    input  logic              d_hwrite,
    input  logic [2:0]        d_hsize,
    input  logic [DATA_W-1:0] d_hwdata,
    output logic [DATA_W-1:0] d_hrdata,
    output logic              d_hready,
    output logic              d_hresp,
    input  logic [1:0]        i_htrans,
    input  logic [ADDR_W-1:0] i_haddr,
    input  logic              i_hwrite,
    input  logic [2:0]        i_hsize,
    input  logic [DATA_W-1:0] i_hwdata,
    output logic [DATA_W-1:0] i_hrdata,
    output logic              i_hready,
    output logic              i_hresp,
    output logic [1:0]        s_htrans,
    output logic [ADDR_W-1:0] s_haddr,
    output logic              s_hwrite,
    output logic [2:0]        s_hsize,
    output logic [DATA_W-1:0] s_hwdata,
    input  logic [DATA_W-1:0] s_hrdata,
    input  logic              s_hready,
    input  logic              s_hresp
);

    localparam int unsigned CNT_W = $clog2(MAX_D_GRANTS + 1);

    logic              d_cand, i_cand;
    logic [ADDR_W-1:0] d_a_haddr, i_a_haddr;
    logic              d_a_hwrite, i_a_hwrite;
    logic [2:0]        d_a_hsize, i_a_hsize;
    logic              go, i_wins, grant_d, grant_i;
    logic [CNT_W-1:0]  d_cnt;
    owner_e            owner;

    nanorv32_ahb_arb_in_stage #(.ADDR_W(ADDR_W)) u_stage_d (
        .clk      (clk),
        .rst      (rst),
        .htrans   (d_htrans),
        .haddr    (d_haddr),
        .hwrite   (d_hwrite),
        .hsize    (d_hsize),
        .grant    (grant_d),
        .s_hready (s_hready),
        .hready   (d_hready),
        .cand     (d_cand),
        .a_haddr  (d_a_haddr),
        .a_hwrite (d_a_hwrite),
        .a_hsize  (d_a_hsize)
    );

    nanorv32_ahb_arb_in_stage #(.ADDR_W(ADDR_W)) u_stage_i (
        .clk      (clk),
        .rst      (rst),
        .htrans   (i_htrans),
        .haddr    (i_haddr),
        .hwrite   (i_hwrite),
        .hsize    (i_hsize),
        .grant    (grant_i),
        .s_hready (s_hready),
        .hready   (i_hready),
        .cand     (i_cand),
        .a_haddr  (i_a_haddr),
        .a_hwrite (i_a_hwrite),
        .a_hsize  (i_a_hsize)
    );

    // Scheduler: D first unless I has waited through MAX_D_GRANTS D grants.
    always_comb begin
        go      = s_hready & ~rst;
        i_wins  = i_cand & (~d_cand | (d_cnt == CNT_W'(MAX_D_GRANTS)));
        grant_i = go & i_wins;
        grant_d = go & d_cand & ~i_wins;
    end

    // Count D grants that overtook a waiting I; saturates at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_cnt <= '0;
        end else if (grant_i || !i_cand) begin
            d_cnt <= '0;
        end else if (grant_d && (d_cnt != CNT_W'(MAX_D_GRANTS))) begin
            d_cnt <= d_cnt + CNT_W'(1);
        end
    end

    // Data-phase owner advances only when the slave completes a phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner <= OWN_NONE;
        end else if (s_hready) begin
            owner <= grant_d ? OWN_D : (grant_i ? OWN_I : OWN_NONE);
        end
    end

    // Slave address phase from the granted stage; every forwarded transfer goes out as NONSEQ.
    always_comb begin
        s_htrans = HTRANS_IDLE;
        s_haddr  = '0;
        s_hwrite = 1'b0;
        s_hsize  = 3'd0;
        if (grant_d) begin
            s_htrans = HTRANS_NONSEQ;
            s_haddr  = d_a_haddr;
            s_hwrite = d_a_hwrite;
            s_hsize  = d_a_hsize;
        end else if (grant_i) begin
            s_htrans = HTRANS_NONSEQ;
            s_haddr  = i_a_haddr;
            s_hwrite = i_a_hwrite;
            s_hsize  = i_a_hsize;
        end
    end

    // Data-phase muxes: write data from the owner, response and read data only to the owner.
    always_comb begin
        s_hwdata = '0;
        d_hrdata = '0;
        i_hrdata = '0;
        d_hresp  = HRESP_OKAY;
        i_hresp  = HRESP_OKAY;
        if (owner == OWN_D) begin
            s_hwdata = d_hwdata;
            d_hrdata = s_hrdata;
            d_hresp  = (s_hresp == HRESP_ERROR) ? HRESP_ERROR : HRESP_OKAY;
        end else if (owner == OWN_I) begin
            s_hwdata = i_hwdata;
            i_hrdata = s_hrdata;
            i_hresp  = (s_hresp == HRESP_ERROR) ? HRESP_ERROR : HRESP_OKAY;
        end
    end

endmodule
